image_resize_bicubic_sched: RTL

- Horizontal-pass scheduler for the bicubic resize datapath: walks a destination frame (dst_w x dst_h), maps each output pixel to a source position, and issues one 4-tap request per output pixel.
- Each request carries four clamped source column indices and four signed weights. The 4-tap multiply/accumulate/clamp unit consumes the weights, and a line-buffer reader consumes the indices.
- Tracks outstanding results returned by the cal unit and reports frame completion.

---
 rtl/image_resize_pkg.sv | 45 ++++
 rtl/bicubic_weight_rom.sv | 17 +
 rtl/image_resize_bicubic_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/image_resize_pkg.sv
// Shared sizes, Q16 constants, bicubic weight table and FSM encoding for the
// bicubic resize horizontal scheduler.
package image_resize_pkg;

  localparam int unsigned W_DIM      = 12;
  localparam int unsigned W_WGT      = 10;
  localparam int unsigned PHASE_BITS = 4;
  localparam int unsigned STEP_W     = 20;

  localparam int unsigned Q16_ONE  = 32'h1_0000;
  localparam int unsigned Q16_HALF = 32'h0_8000;

  // Accumulator wide enough to address any W_DIM source column in Q16.
  localparam int unsigned ACC_W = W_DIM + 17;

  typedef logic signed [W_WGT-1:0] wgt_t;

  // Keys kernel (a = -0.5), Q8, rows sum to exactly 256.
  localparam wgt_t WGT_TABLE [16][4] = '{
    '{wgt_t'(0),   wgt_t'(256), wgt_t'(0),   wgt_t'(0)},
    '{wgt_t'(-7),  wgt_t'(253), wgt_t'(10),  wgt_t'(0)},
    '{wgt_t'(-12), wgt_t'(247), wgt_t'(23),  wgt_t'(-2)},
    '{wgt_t'(-16), wgt_t'(237), wgt_t'(39),  wgt_t'(-4)},
    '{wgt_t'(-18), wgt_t'(222), wgt_t'(58),  wgt_t'(-6)},
    '{wgt_t'(-19), wgt_t'(206), wgt_t'(78),  wgt_t'(-9)},
    '{wgt_t'(-19), wgt_t'(186), wgt_t'(100), wgt_t'(-11)},
    '{wgt_t'(-18), wgt_t'(166), wgt_t'(122), wgt_t'(-14)},
    '{wgt_t'(-16), wgt_t'(144), wgt_t'(144), wgt_t'(-16)},
    '{wgt_t'(-14), wgt_t'(122), wgt_t'(166), wgt_t'(-18)},
    '{wgt_t'(-11), wgt_t'(100), wgt_t'(186), wgt_t'(-19)},
    '{wgt_t'(-9),  wgt_t'(78),  wgt_t'(206), wgt_t'(-19)},
    '{wgt_t'(-6),  wgt_t'(58),  wgt_t'(222), wgt_t'(-18)},
    '{wgt_t'(-4),  wgt_t'(39),  wgt_t'(237), wgt_t'(-16)},
    '{wgt_t'(-2),  wgt_t'(23),  wgt_t'(247), wgt_t'(-12)},
    '{wgt_t'(0),   wgt_t'(10),  wgt_t'(253), wgt_t'(-7)}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/bicubic_weight_rom.sv
// Combinational phase -> four signed bicubic weights.
module bicubic_weight_rom
  import image_resize_pkg::*;
(
  input  logic [PHASE_BITS-1:0] i_phase,
  output logic [W_WGT-1:0]      o_wgt0,
  output logic [W_WGT-1:0]      o_wgt1,
  output logic [W_WGT-1:0]      o_wgt2,
  output logic [W_WGT-1:0]      o_wgt3
);

  assign o_wgt0 = WGT_TABLE[i_phase][0];
  assign o_wgt1 = WGT_TABLE[i_phase][1];
  assign o_wgt2 = WGT_TABLE[i_phase][2];
  assign o_wgt3 = WGT_TABLE[i_phase][3];

endmodule

// File: rtl/image_resize_bicubic_sched.sv
// Horizontal-pass bicubic scheduler: walks the destination frame and issues
// one registered 4-tap request (clamped columns + weights) per output pixel.
module image_resize_bicubic_sched
  import image_resize_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W_DIM-1:0]  cfg_src_w,
  input  logic [W_DIM-1:0]  cfg_dst_w,
  input  logic [W_DIM-1:0]  cfg_dst_h,
  input  logic [STEP_W-1:0] cfg_step,
  output logic              busy,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [W_DIM-1:0]  req_row,
  output logic [W_DIM-1:0]  req_tap0,
  output logic [W_DIM-1:0]  req_tap1,
  output logic [W_DIM-1:0]  req_tap2,
  output logic [W_DIM-1:0]  req_tap3,
  output logic [W_WGT-1:0]  req_wgt0,
  output logic [W_WGT-1:0]  req_wgt1,
  output logic [W_WGT-1:0]  req_wgt2,
  output logic [W_WGT-1:0]  req_wgt3,
  output logic              req_eol,
  output logic              req_eof,
  input  logic              cal_valid_i
);

  localparam int unsigned FRAC_BITS = $clog2(Q16_ONE);
  localparam int unsigned TAP_W     = W_DIM + 2;
  localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);

  state_t r_state, w_state_nxt;

  logic [W_DIM-1:0]        r_src_w, r_dst_w, r_dst_h, r_x, r_y, w_x_n, w_y_n;
  logic [STEP_W-1:0]       r_step;
  logic signed [ACC_W-1:0] r_acc, w_acc_n, w_acc0;
  logic signed [TAP_W-1:0] w_int;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    r_busy, r_done, r_req_valid, r_req_eol, r_req_eof;
  logic [W_DIM-1:0]        r_req_row, r_req_tap0, r_req_tap1, r_req_tap2, r_req_tap3;
  logic [W_WGT-1:0]        r_req_wgt0, r_req_wgt1, r_req_wgt2, r_req_wgt3;
  logic [W_WGT-1:0]        w_wgt0, w_wgt1, w_wgt2, w_wgt3;
  logic                    w_xfer, w_cal, w_load, w_zero_cfg, w_drain_done;
  logic                    w_eol_n, w_eof_n;

  function automatic logic [W_DIM-1:0] clamp_tap(input logic signed [TAP_W-1:0] v,
                                                 input logic [W_DIM-1:0] w);
    if (v < 0)                         return '0;
    else if (v >= signed'({2'b00, w})) return w - W_DIM'(1);
    else                               return v[W_DIM-1:0];
  endfunction

  assign w_xfer       = r_req_valid && req_ready;
  assign w_cal        = cal_valid_i && (r_cnt != '0);
  assign w_zero_cfg   = (cfg_src_w == '0) || (cfg_dst_w == '0) || (cfg_dst_h == '0);
  assign w_drain_done = (r_state == ST_DRAIN) && (r_cnt == '0);
  assign w_load       = (r_state == ST_INIT) || ((r_state == ST_RUN) && w_xfer && !r_req_eof);
  assign w_acc0       = signed'(ACC_W'(r_step >> 1)) - signed'(ACC_W'(Q16_HALF));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = w_zero_cfg ? ST_DRAIN : ST_INIT;
      ST_INIT:  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_xfer && r_req_eof) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_cnt == '0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Position of the request to be presented next (first pixel or successor).
  always_comb begin
    w_x_n   = r_x;
    w_y_n   = r_y;
    w_acc_n = r_acc;
    if (r_state == ST_INIT) begin
      w_x_n   = '0;
      w_y_n   = '0;
      w_acc_n = w_acc0;
    end else if (r_x == r_dst_w - W_DIM'(1)) begin
      w_x_n   = '0;
      w_y_n   = r_y + W_DIM'(1);
      w_acc_n = w_acc0;
    end else begin
      w_x_n   = r_x + W_DIM'(1);
      w_acc_n = r_acc + signed'(ACC_W'(r_step));
    end
  end

  assign w_int   = TAP_W'(w_acc_n >>> FRAC_BITS);
  assign w_eol_n = (w_x_n == r_dst_w - W_DIM'(1));
  assign w_eof_n = w_eol_n && (w_y_n == r_dst_h - W_DIM'(1));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_xfer && !w_cal)      w_cnt_nxt = r_cnt + CNT_W'(1);
    else if (!w_xfer && w_cal) w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  bicubic_weight_rom u_rom (
    .i_phase (w_acc_n[FRAC_BITS-1 -: PHASE_BITS]),
    .o_wgt0  (w_wgt0),
    .o_wgt1  (w_wgt1),
    .o_wgt2  (w_wgt2),
    .o_wgt3  (w_wgt3)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_req_valid <= 1'b0;
      r_cnt       <= '0;
      r_src_w     <= '0;
      r_dst_w     <= '0;
      r_dst_h     <= '0;
      r_step      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_req_row   <= '0;
      r_req_tap0  <= '0;
      r_req_tap1  <= '0;
      r_req_tap2  <= '0;
      r_req_tap3  <= '0;
      r_req_wgt0  <= '0;
      r_req_wgt1  <= '0;
      r_req_wgt2  <= '0;
      r_req_wgt3  <= '0;
      r_req_eol   <= 1'b0;
      r_req_eof   <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_cnt       <= w_cnt_nxt;
      r_req_valid <= (w_state_nxt == ST_RUN) && (w_cnt_nxt < CNT_W'(MAX_OUTSTANDING));
      if ((r_state == ST_IDLE) && start) begin
        r_src_w <= cfg_src_w;
        r_dst_w <= cfg_dst_w;
        r_dst_h <= cfg_dst_h;
        r_step  <= cfg_step;
        r_busy  <= 1'b1;
      end
      if (w_drain_done) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
      if (w_load) begin
        r_x        <= w_x_n;
        r_y        <= w_y_n;
        r_acc      <= w_acc_n;
        r_req_row  <= w_y_n;
        r_req_tap0 <= clamp_tap(w_int - TAP_W'(1), r_src_w);
        r_req_tap1 <= clamp_tap(w_int, r_src_w);
        r_req_tap2 <= clamp_tap(w_int + TAP_W'(1), r_src_w);
        r_req_tap3 <= clamp_tap(w_int + TAP_W'(2), r_src_w);
        r_req_wgt0 <= w_wgt0;
        r_req_wgt1 <= w_wgt1;
        r_req_wgt2 <= w_wgt2;
        r_req_wgt3 <= w_wgt3;
        r_req_eol  <= w_eol_n;
        r_req_eof  <= w_eof_n;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign req_valid = r_req_valid;
  assign req_row   = r_req_row;
  assign req_tap0  = r_req_tap0;
  assign req_tap1  = r_req_tap1;
  assign req_tap2  = r_req_tap2;
  assign req_tap3  = r_req_tap3;
  assign req_wgt0  = r_req_wgt0;
  assign req_wgt1  = r_req_wgt1;
  assign req_wgt2  = r_req_wgt2;
  assign req_wgt3  = r_req_wgt3;
  assign req_eol   = r_req_eol;
  assign req_eof   = r_req_eof;

endmodule
